// File: rtl/bist_pkg.sv
// bist_pkg: controller state type and default TPG/MISR constants for bist_engine.
package bist_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int          DEF_W     = 4;
    localparam int          DEF_R     = 3;
    localparam int          DEF_N_PAT = 15;
    localparam logic [31:0] DEF_POLY  = 32'h2;
    localparam logic [31:0] DEF_SEED  = 32'hffff_ffff;
endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: Galois LFSR with parallel data injection; TPG when d=0, MISR otherwise.
module lfsr_galois
    import bist_pkg::*;
#(
    parameter int           N    = DEF_W,
    parameter logic [N-1:0] POLY = N'(DEF_POLY),
    parameter logic [N-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [N-1:0] nxt;
    // Bit 0 of POLY is ignored: stage 0 always takes the MSB directly
    always_comb nxt = {q[N-2:0], q[N-1]} ^ ({N{q[N-1]}} & {POLY[N-1:1], 1'b0}) ^ d;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q <= INIT;
        else if (load)
            q <= load_val;
        else if (en)
            q <= nxt;
endmodule

// File: rtl/bist_engine.sv
// bist_engine: LFSR pattern generator + MISR compactor with run/compare controller.
// RESP_PIPE_EN registers dut_resp before the MISR and stretches RUN by one cycle.
module bist_engine
    import bist_pkg::*;
#(
    parameter int           W      = DEF_W,
    parameter logic [W-1:0] POLY   = W'(DEF_POLY),
    parameter logic [W-1:0] SEED   = W'(DEF_SEED),
    parameter int           R      = DEF_R,
    parameter logic [R-1:0] MPOLY  = R'(DEF_POLY),
    parameter int           N_PAT  = DEF_N_PAT,
    parameter logic [R-1:0] GOLDEN = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] tpg_q,
    input  logic [R-1:0] dut_resp,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [R-1:0] sig
);
    localparam int CW = $clog2(N_PAT + 1);
`ifdef RESP_PIPE_EN
    localparam logic [CW-1:0] LAST = CW'(N_PAT);
`else
    localparam logic [CW-1:0] LAST = CW'(N_PAT - 1);
`endif
    state_t        state;
    logic [CW-1:0] count;
    logic [R-1:0]  resp;
    logic          go;
    logic          misr_en;
    assign busy = state == RUN;
    assign done = state == DONE;
    assign go   = start && !busy;
    assign pass = done && sig == GOLDEN;
`ifdef RESP_PIPE_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            resp <= '0;
        else
            resp <= dut_resp;
    // First RUN cycle holds no valid registered response yet
    assign misr_en = busy && count != '0;
`else
    assign resp    = dut_resp;
    assign misr_en = busy;
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= go ? RUN : (busy && count == LAST) ? DONE : state;
            count <= go ? '0 : (busy && count != LAST) ? count + 1'b1 : count;
        end
    lfsr_galois #(.N(W), .POLY(POLY), .INIT(SEED)) u_tpg (
        .clk(clk), .rst(rst), .load(go), .load_val(SEED),
        .en(busy), .d({W{1'b0}}), .q(tpg_q)
    );
    lfsr_galois #(.N(R), .POLY(MPOLY), .INIT({R{1'b0}})) u_misr (
        .clk(clk), .rst(rst), .load(go), .load_val({R{1'b0}}),
        .en(misr_en), .d(resp), .q(sig)
    );
endmodule

// File: tb/tb_bist_engine.sv
// tb_bist_engine: random DUT truth tables checked against a polynomial-arithmetic model.
module tb_bist_engine;
    localparam int NP = 15;
`ifdef RESP_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int RL  = NP + EXTRA;
    localparam int RLB = 3 + EXTRA;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [2:0] tab [16];
    logic [2:0] resp_a;
    logic [2:0] resp_bc = 3'b001;
    logic [3:0] tpg_a, tpg_b, tpg_c;
    logic [2:0] sig_a, sig_b, sig_c;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
    int total = 0, bad = 0;

    always #5 clk = ~clk;
    always_comb resp_a = tab[tpg_a];

    bist_engine u_a (
        .clk(clk), .rst(rst), .start(start), .tpg_q(tpg_a), .dut_resp(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .sig(sig_a)
    );
    bist_engine #(.N_PAT(3), .GOLDEN(3'b111)) u_b (
        .clk(clk), .rst(rst), .start(start), .tpg_q(tpg_b), .dut_resp(resp_bc),
        .busy(busy_b), .done(done_b), .pass(pass_b), .sig(sig_b)
    );
    bist_engine #(.N_PAT(3), .GOLDEN(3'b110)) u_c (
        .clk(clk), .rst(rst), .start(start), .tpg_q(tpg_c), .dut_resp(resp_bc),
        .busy(busy_c), .done(done_c), .pass(pass_c), .sig(sig_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Multiply by x modulo the full characteristic polynomial p of degree w
    function automatic int unsigned mulx(input int unsigned v, input int unsigned p, input int w);
        v = v << 1;
        if (((v >> w) & 1) != 0) v = v ^ p;
        return v;
    endfunction

    initial begin
        int unsigned p, s;
        int nseen;
        bit seen [16];
        foreach (tab[i]) tab[i] = 3'b000;
        repeat (2) @(negedge clk);
        check("rst_tpg", tpg_a, 4'hf);
        check("rst_sig", sig_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_tpg", tpg_a, 4'hf);
        check("idle_busy", busy_a, 0);
        for (int r = 0; r < 4; r++) begin
            foreach (tab[i]) tab[i] = (r == 3) ? 3'b000 : 3'($urandom_range(7));
            foreach (seen[i]) seen[i] = 1'b0;
            nseen = 0;
            p = 4'hf;
            s = 0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < RL; i++) begin
                check("busy", busy_a, 1);
                check("done_b", done_b, i >= RLB);
                if (i == 0) begin
                    check("b_clr", sig_b, 0);
                    check("b_seed", tpg_b, 4'hf);
                end
                if (i < NP) begin
                    check("tpg", tpg_a, p);
                    if (!seen[tpg_a]) nseen++;
                    seen[tpg_a] = 1'b1;
                    s = mulx(s, 'hb, 3) ^ tab[p];
                end
                p = mulx(p, 'h13, 4);
                start = (i == 2);
                @(negedge clk);
            end
            start = 1'b0;
            check("done", done_a, 1);
            check("busy_end", busy_a, 0);
            check("sig", sig_a, s);
            check("pass", pass_a, s == 0);
            check("cover", nseen, 15);
            check("no_zero", seen[0], 0);
            check("b_sig", sig_b, 3'b111);
            check("b_pass", pass_b, 1);
            check("c_sig", sig_c, 3'b111);
            check("c_done", done_c, 1);
            check("c_pass", pass_c, 0);
            repeat (3) @(negedge clk);
            check("hold_tpg", tpg_a, p);
            check("hold_sig", sig_a, s);
            check("hold_done", done_a, 1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", busy_a, 1);
        rst = 1'b0;
        #1;
        check("abort_tpg", tpg_a, 4'hf);
        check("abort_sig", sig_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_b_sig", sig_b, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_busy", busy_a, 0);
        check("post_tpg", tpg_a, 4'hf);
        check("post_done", done_a, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bist_engine.md
Name: bist_engine

Overview:
Parametrised built-in self-test engine for combinational blocks.
- A Galois LFSR test-pattern generator of configurable width and polynomial drives the DUT inputs.
- A multiple-input signature register (MISR) compresses the DUT responses.
- A controller FSM runs a fixed number of patterns, then compares the final signature with a golden value.
- Sits between the pattern source and a DUT as a reusable test wrapper.

Parameters:
- W, 4: TPG (LFSR) width, minimum 2.
- POLY, 'h2: TPG feedback mask. Bit k (1..W-1) set means XOR of the MSB into stage k. Bit 0 is ignored. The default gives x^4+x+1.
- SEED, all-ones: TPG reset/restart value. Must be non-zero.
- R, 3: DUT response width / MISR width, minimum 2.
- MPOLY, 'h2: MISR feedback mask, same encoding as POLY.
- N_PAT, 15: patterns applied per run, minimum 1.
- GOLDEN, 0: expected final signature, R bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; sampled in IDLE or DONE
- tpg_q  out  W  current test pattern, to DUT inputs
- dut_resp  in  R  DUT response to tpg_q
- busy  out  1  high while in RUN
- done  out  1  high while in DONE
- pass  out  1  done && (sig == GOLDEN)
- sig  out  R  MISR contents

Behaviour:
Reset (rst low, asynchronous):
- state=IDLE, tpg_q=SEED, sig=0, count=0.
- busy=0, done=0, pass=0.
- Reset mid-run aborts immediately to these values. There is no partial result.

LFSR step (Galois), with msb = q[W-1]:
- next[0] = msb
- next[k] = q[k-1] ^ (POLY[k] & msb), for k=1..W-1

MISR step, with msb = m[R-1] and d = dut_resp:
- next[0] = msb ^ d[0]
- next[k] = m[k-1] ^ (MPOLY[k] & msb) ^ d[k]

FSM:
- IDLE: start=1 -> RUN. tpg_q loads SEED, sig clears to 0, count clears to 0.
- RUN, every cycle:
  - sig absorbs dut_resp (MISR step).
  - tpg_q advances (LFSR step).
  - count increments.
  - When count==N_PAT-1 -> DONE. The last response is absorbed on this edge. The LFSR step on this edge is don't-care but implemented as a normal advance.
- DONE: tpg_q, sig and count hold.
  - start=1 -> RUN, with the same reload as in IDLE (restart).
  - start=0 -> stay in DONE.

Timing:
- start is ignored during RUN.
- Run latency: exactly N_PAT cycles in RUN. done rises on the edge that absorbs the N_PAT-th response.
- The DUT is combinational. dut_resp must be valid in the same cycle its tpg_q is presented.
- The count register is $clog2(N_PAT+1) bits wide. There is no wrap within a run.
- pass is combinational from registered state only. It is 0 outside DONE.

Optional Feature:
Macro RESP_PIPE_EN.
- Defined: dut_resp is registered (R-bit register, async reset to 0) before the MISR, matching a registered-output DUT.
  - The MISR skips absorption on the first RUN cycle.
  - RUN lasts N_PAT+1 cycles, so the last response is still absorbed.
  - Signature values are identical to the undefined case for the same DUT.
- Undefined: dut_resp feeds the MISR directly. RUN lasts N_PAT cycles.

Decomposition:
- Package bist_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - default polynomial and seed constants
- One sub-module, lfsr_galois (parameters N, POLY; ports clk, rst, load, load_val, en, d, q). It is instantiated twice:
  - as the TPG, with d=0
  - as the MISR, with d=dut_resp and load_val=0
- The FSM and counter stay in bist_engine.

Test Plan:
1. Reset, then start pulse, with defaults -> tpg_q sequence 1111, 1101, 1001, 0001 on the first four RUN cycles. busy=1 throughout RUN.
2. R=3, MPOLY='h2, N_PAT=3, dut_resp held at 3'b001 -> sig goes 001, 011, 111. done=1 after 3 RUN cycles. pass=1 when GOLDEN=3'b111.
3. Same as 2 with GOLDEN=3'b110 -> done=1, pass=0. Then start again in DONE -> sig clears, tpg_q=SEED, identical sig=111 at the end.
4. dut_resp tied to 0, N_PAT=15 -> sig=0 at done. tpg_q covers all 15 non-zero states exactly once.
5. rst low at RUN cycle 5 -> same cycle: tpg_q=SEED, sig=0, busy=0, done=0. A start pulse in mid-RUN has no effect.
6. RESP_PIPE_EN defined, DUT emulated with a registered output, stimulus as in 2 -> sig=111. RUN lasts 4 cycles.
